// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// multicycle_ctrl_pkg
// Shared encodings for the multicycle RV32I control unit and its datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_S  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  // Shared with the immediate generator in the datapath
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_BR    = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_ZERO = 2'd2
  } alu_src_a_t;

  typedef enum logic [3:0] {
    CL_OP_IMM  = 4'd0,
    CL_OP      = 4'd1,
    CL_LOAD    = 4'd2,
    CL_STORE   = 4'd3,
    CL_BRANCH  = 4'd4,
    CL_LUI     = 4'd5,
    CL_AUIPC   = 4'd6,
    CL_JAL     = 4'd7,
    CL_JALR    = 4'd8,
    CL_FENCE   = 4'd9,
    CL_SYSTEM  = 4'd10,
    CL_ILLEGAL = 4'd11
  } iclass_t;

  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_fence  = 7'b0001111;
  localparam logic [6:0] c_opc_system = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// ctrl_decode
// Combinational RV32I opcode-to-instruction-class decode.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    iclass
);

  always_comb begin
    iclass = CL_ILLEGAL;
    case (opcode)
      c_opc_op_imm: iclass = CL_OP_IMM;
      c_opc_op:     iclass = CL_OP;
      c_opc_load:   iclass = CL_LOAD;
      c_opc_store:  iclass = CL_STORE;
      c_opc_branch: iclass = CL_BRANCH;
      c_opc_lui:    iclass = CL_LUI;
      c_opc_auipc:  iclass = CL_AUIPC;
      c_opc_jal:    iclass = CL_JAL;
      c_opc_jalr:   iclass = CL_JALR;
      c_opc_fence:  iclass = CL_FENCE;
      c_opc_system: iclass = CL_SYSTEM;
      default:      iclass = CL_ILLEGAL;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// Multicycle RV32I control FSM driving memory, PC/IR, ALU and write-back muxes.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] instr,
  input  logic         mem_ready,
  input  logic         br_taken,
  output logic         mem_req,
  output logic         mem_we,
  output logic         mem_addr_sel,
  output logic         ir_write,
  output logic         pc_write,
  output logic         pc_src,
  output logic         reg_write,
  output logic [1:0]   alu_src_a,
  output logic         alu_src_b,
  output logic [1:0]   alu_op,
  output logic [2:0]   imm_sel,
  output logic [1:0]   wb_sel,
  output logic         trap,
  output logic [2:0]   state
);

  state_t  r_state;
  logic    r_run;
  iclass_t w_iclass;
  logic    unused_instr;

  assign unused_instr = ^instr[N-1:7];

  ctrl_decode u_decode (
    .opcode (instr[6:0]),
    .iclass (w_iclass)
  );

  // r_run delays the RST_S exit by one edge so RST_S spans a full cycle after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_S;
      r_run   <= 1'b0;
    end else begin
      case (r_state)
        RST_S: begin
          r_run <= 1'b1;
          if (r_run) r_state <= FETCH;
        end
        FETCH:  if (mem_ready) r_state <= DECODE;
        DECODE: begin
          case (w_iclass)
            CL_FENCE:              r_state <= FETCH;
            CL_SYSTEM, CL_ILLEGAL: r_state <= TRAP;
            default:               r_state <= EXEC;
          endcase
        end
        EXEC: begin
          case (w_iclass)
            CL_LOAD, CL_STORE: r_state <= MEM;
            CL_BRANCH:         r_state <= FETCH;
            CL_OP_IMM, CL_OP, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR:
                               r_state <= WB;
            default:           r_state <= TRAP;
          endcase
        end
        MEM:     if (mem_ready) r_state <= (w_iclass == CL_LOAD) ? WB : FETCH;
        WB:      r_state <= FETCH;
        TRAP:    r_state <= TRAP;
        default: r_state <= TRAP;
      endcase
    end
  end

  // Decoded straight from the state register so an async reset clears every strobe at once
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = SRCA_RS1;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    imm_sel      = IMM_I;
    wb_sel       = WB_ALU;
    trap         = 1'b0;
    case (r_state)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_PC;
        alu_src_b = 1'b1;
        imm_sel   = IMM_B;
      end
      EXEC: begin
        case (w_iclass)
          CL_OP_IMM, CL_OP: begin
            alu_src_b = (w_iclass == CL_OP_IMM);
            alu_op    = ALU_FUNCT;
          end
          CL_LOAD:  alu_src_b = 1'b1;
          CL_STORE: begin
            alu_src_b = 1'b1;
            imm_sel   = IMM_S;
          end
          CL_BRANCH: begin
            alu_op   = ALU_BR;
            imm_sel  = IMM_B;
            pc_write = br_taken;
            pc_src   = 1'b1;
          end
          CL_LUI, CL_AUIPC: begin
            imm_sel   = IMM_U;
            alu_src_b = 1'b1;
            alu_src_a = (w_iclass == CL_LUI) ? SRCA_ZERO : SRCA_PC;
          end
          CL_JAL, CL_JALR: begin
            imm_sel   = (w_iclass == CL_JAL) ? IMM_J : IMM_I;
            alu_src_a = (w_iclass == CL_JAL) ? SRCA_PC : SRCA_RS1;
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (w_iclass == CL_STORE);
      end
      WB: begin
        reg_write = 1'b1;
        case (w_iclass)
          CL_LOAD:         wb_sel = WB_MEM;
          CL_JAL, CL_JALR: wb_sel = WB_PC4;
          default:         wb_sel = WB_ALU;
        endcase
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// Randomized bench: per-instruction expected cycle trace built from the ISA rules.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int N = 32;

  localparam int K_OPIMM = 0, K_OP = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_LUI = 5;
  localparam int K_AUIPC = 6, K_JAL = 7, K_JALR = 8, K_FENCE = 9, K_SYS = 10, K_ILL = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] instr = '0;
  logic         mem_ready = 1'b0;
  logic         br_taken = 1'b0;
  logic         mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write;
  logic [1:0]   alu_src_a, alu_op, wb_sel;
  logic         alu_src_b, trap;
  logic [2:0]   imm_sel, state;
  logic [20:0]  obs;

  always #5 clk = ~clk;

  multicycle_ctrl #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .mem_ready    (mem_ready),
    .br_taken     (br_taken),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .wb_sel       (wb_sel),
    .trap         (trap),
    .state        (state)
  );

  assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src,
                reg_write, alu_src_a, alu_src_b, alu_op, imm_sel, wb_sel, trap};

  typedef struct {
    logic [20:0] v;
    logic        rdy;
    logic        br;
    logic [31:0] ins;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [20:0] vec(input logic [2:0] st, input logic mreq, mwe, masel,
                                      irw, pcw, pcs, rw, input logic [1:0] asa,
                                      input logic asb, input logic [1:0] aop,
                                      input logic [2:0] imm, input logic [1:0] wb,
                                      input logic tr);
    return {st, mreq, mwe, masel, irw, pcw, pcs, rw, asa, asb, aop, imm, wb, tr};
  endfunction

  function automatic logic [6:0] opc_of(input int k);
    case (k)
      K_OPIMM: return 7'h13;
      K_OP:    return 7'h33;
      K_LOAD:  return 7'h03;
      K_STORE: return 7'h23;
      K_BR:    return 7'h63;
      K_LUI:   return 7'h37;
      K_AUIPC: return 7'h17;
      K_JAL:   return 7'h6F;
      K_JALR:  return 7'h67;
      K_FENCE: return 7'h0F;
      default: return 7'h73;
    endcase
  endfunction

  function automatic int kind_of(input logic [6:0] op);
    for (int k = 0; k <= K_SYS; k++)
      if (opc_of(k) == op) return k;
    return K_ILL;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [20:0] v, input logic rdy, input logic br, input logic [31:0] ins);
    rec_t r;
    r.v = v; r.rdy = rdy; r.br = br; r.ins = ins;
    q.push_back(r);
  endtask

  // Expected trace of one instruction: fetch stalls, decode, then the class-specific tail
  task automatic plan_instr(input logic [31:0] ins, input int fs, input int ms,
                            input logic br, output int kind);
    logic [1:0] asa, aop, wb;
    logic       asb, pcw, pcs;
    logic [2:0] imm;
    bit         to_mem, to_wb;
    kind = kind_of(ins[6:0]);
    for (int i = 0; i < fs; i++)
      push(vec(FETCH, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0), 1'b0, rbit(), $urandom);
    push(vec(FETCH, 1, 0, 0, 1, 1, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0), 1'b1, rbit(), $urandom);
    push(vec(DECODE, 0, 0, 0, 0, 0, 0, 0, 2'd1, 1, 2'd0, 3'd2, 2'd0, 0), rbit(), rbit(), ins);
    if (kind == K_FENCE) return;
    if (kind == K_SYS || kind == K_ILL) begin
      repeat (10)
        push(vec(TRAP, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 1), rbit(), rbit(), ins);
      return;
    end
    asa = 2'd0; aop = 2'd0; wb = 2'd0; asb = 1'b1; pcw = 1'b0; pcs = 1'b0; imm = 3'd0;
    to_mem = 0; to_wb = 1;
    case (kind)
      K_OPIMM: aop = 2'd2;
      K_OP:    begin aop = 2'd2; asb = 1'b0; end
      K_LOAD:  begin to_mem = 1; wb = 2'd1; end
      K_STORE: begin to_mem = 1; to_wb = 0; imm = 3'd1; end
      K_BR:    begin asb = 1'b0; aop = 2'd1; imm = 3'd2; pcw = br; pcs = 1'b1; to_wb = 0; end
      K_LUI:   begin imm = 3'd3; asa = 2'd2; end
      K_AUIPC: begin imm = 3'd3; asa = 2'd1; end
      K_JAL:   begin imm = 3'd4; asa = 2'd1; pcw = 1'b1; pcs = 1'b1; wb = 2'd2; end
      default: begin pcw = 1'b1; pcs = 1'b1; wb = 2'd2; end
    endcase
    push(vec(EXEC, 0, 0, 0, 0, pcw, pcs, 0, asa, asb, aop, imm, 2'd0, 0), rbit(), br, ins);
    if (to_mem) begin
      for (int i = 0; i < ms; i++)
        push(vec(MEM, 1, kind == K_STORE, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0), 1'b0, rbit(), ins);
      push(vec(MEM, 1, kind == K_STORE, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0), 1'b1, rbit(), ins);
    end
    if (to_wb)
      push(vec(WB, 0, 0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 3'd0, wb, 0), rbit(), rbit(), ins);
  endtask

  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      mem_ready = r.rdy;
      br_taken  = r.br;
      instr     = r.ins;
      @(negedge clk);
      check_eq($sformatf("cycle_st%0d", r.v[20:18]), 32'(obs), 32'(r.v));
    end
  endtask

  // Called at a negedge: assert rst between edges and expect the outputs to clear at once
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_eq({tag, "_memreq"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_out"}, 32'(obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    push(21'd0, rbit(), rbit(), $urandom);
  endtask

  task automatic run_one(input logic [31:0] ins, input int fs, input int ms, input logic br);
    int kind;
    plan_instr(ins, fs, ms, br, kind);
    run_q();
    if (kind == K_SYS || kind == K_ILL) do_reset("trap_rst");
  endtask

  task automatic midfetch_reset();
    push(vec(FETCH, 1, 0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 0), 1'b0, rbit(), $urandom);
    run_q();
    do_reset("midfetch_rst");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rw;
    int          sel, k;
    logic [6:0]  op;
    repeat (2) @(negedge clk);
    check_eq("por_out", 32'(obs), 32'd0);
    rst = 1'b0;
    push(21'd0, 1'b1, 1'b0, 32'd0);

    run_one(32'h00500093, 0, 0, 1'b0);   // addi x1,x0,5
    run_one(32'h0000A103, 0, 2, 1'b0);   // lw with two MEM stalls
    run_one(32'h00208463, 0, 0, 1'b0);   // beq not taken
    run_one(32'h00208463, 0, 0, 1'b1);   // beq taken
    run_one(32'h0020A023, 0, 0, 1'b0);   // sw
    run_one(32'h0000000F, 1, 0, 1'b0);   // fence
    midfetch_reset();
    run_one(32'h0000007F, 0, 0, 1'b0);   // unknown opcode
    run_one(32'h00000073, 2, 0, 1'b0);   // ecall

    for (int i = 0; i < 150; i++) begin
      sel = int'($urandom_range(0, 99));
      rw  = $urandom;
      if (sel < 3) begin
        do op = 7'($urandom_range(0, 127)); while (kind_of(op) != K_ILL);
      end else if (sel < 5) begin
        op = opc_of(K_SYS);
      end else begin
        k  = int'($urandom_range(0, K_FENCE));
        op = opc_of(k);
      end
      if (sel >= 5 && sel < 8) midfetch_reset();
      run_one({rw[31:7], op}, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rbit());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: N, default 32, datapath/instruction width.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 instr  input  N  current instruction-register contents, valid from DECODE onward.
REQ-005 mem_ready  input  1  memory handshake; completes the pending access when high while mem_req is high.
REQ-006 br_taken  input  1  ALU branch-compare result, valid in EXEC.
REQ-007 mem_req / mem_we / mem_addr_sel  output  1/1/1  access request, write enable, address source (0 = PC, 1 = ALU result).
REQ-008 ir_write / pc_write / pc_src  output  1/1/1  IR load, PC load, PC source (0 = PC+4, 1 = ALU result).
REQ-009 reg_write  output  1  register-file write strobe.
REQ-010 alu_src_a  output  2  ALU A source: 0 = rs1, 1 = PC, 2 = zero.
REQ-011 alu_src_b  output  1  ALU B source: 0 = rs2, 1 = immediate.
REQ-012 alu_op  output  2  ALU operation: 0 = ADD, 1 = branch compare, 2 = funct-decoded.
REQ-013 imm_sel  output  3  immediate format: I = 0, S = 1, B = 2, U = 3, J = 4.
REQ-014 wb_sel  output  2  write-back source: 0 = ALU, 1 = memory data, 2 = PC+4.
REQ-015 trap  output  1  core halted on illegal/system instruction.
REQ-016 state  output  3  current FSM state, for debug.

Function
REQ-017 FSM states: RST_S, FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs are Moore-decoded from the state register and instr[6:0].
REQ-018 Outputs not listed as active for a state are 0; in RST_S and TRAP every strobe (mem_req, ir_write, pc_write, reg_write) is 0.
REQ-019 RST_S -> FETCH unconditionally after one cycle.
REQ-020 FETCH: mem_req = 1, mem_addr_sel = 0; mem_req stays high until mem_ready = 1; in the mem_ready cycle ir_write = 1, pc_write = 1, pc_src = 0, then -> DECODE.
REQ-021 DECODE: alu_src_a = 1, alu_src_b = 1, imm_sel = B, alu_op = ADD (branch-target precompute); next state by opcode: FENCE -> FETCH; SYSTEM or unknown opcode -> TRAP; otherwise -> EXEC.
REQ-022 EXEC, OP-IMM/OP: alu_src_a = 0, alu_src_b = OP-IMM ? 1 : 0, imm_sel = I, alu_op = 2 -> WB.
REQ-023 EXEC, LOAD/STORE: alu_src_a = 0, alu_src_b = 1, imm_sel = I (LOAD) or S (STORE), alu_op = 0 -> MEM.
REQ-024 EXEC, BRANCH: alu_op = 1, imm_sel = B; pc_write = br_taken, pc_src = 1 (target held from DECODE) -> FETCH.
REQ-025 EXEC, LUI/AUIPC: imm_sel = U, alu_src_b = 1, alu_src_a = 2 (LUI) or 1 (AUIPC) -> WB.
REQ-026 EXEC, JAL/JALR: imm_sel = J (JAL) or I (JALR), alu_src_a = 1 (JAL) or 0 (JALR), alu_src_b = 1, pc_write = 1, pc_src = 1 -> WB.
REQ-027 MEM: mem_req = 1, mem_addr_sel = 1, mem_we = STORE; held until mem_ready; then LOAD -> WB, STORE -> FETCH.
REQ-028 WB: reg_write = 1; wb_sel = 1 for LOAD, 2 for JAL/JALR, else 0 -> FETCH.
REQ-029 Cycle counts with mem_ready tied high: ALU/U/jump 4, branch 3, store 4, load 5; each mem_ready-low cycle in FETCH or MEM adds exactly one cycle.
REQ-030 TRAP: trap = 1, state held until rst.
REQ-031 mem_ready while mem_req = 0 is ignored.

Reset
REQ-032 rst = 1 forces state = RST_S immediately (asynchronous), including mid-access; all outputs 0 and trap = 0 while rst is high.
REQ-033 The first FETCH occurs the second rising edge after rst deasserts.

Structure
REQ-034 The shared package holds the state encoding, imm_sel, alu_op, wb_sel and alu_src_a encodings, and the RV32I opcode constants; the immediate generator and datapath share the imm_sel codes.
REQ-035 Single module; an optional sub-module ctrl_decode (combinational opcode-to-class decode) is permitted.

Verification
REQ-036 addi x1,x0,5 (0x00500093), mem_ready = 1 -> states FETCH, DECODE, EXEC, WB; reg_write = 1 only in cycle 4; imm_sel = 0 in EXEC.
REQ-037 lw (0x0000A103), mem_ready low 2 cycles in MEM -> 7 cycles total; wb_sel = 1 in WB; mem_we = 0 throughout.
REQ-038 beq with br_taken = 0, then with br_taken = 1 -> 3 cycles each; pc_write in EXEC is 0 and 1 respectively; imm_sel = 2.
REQ-039 sw (0x0020A023) -> mem_we = 1 in MEM, imm_sel = 1, no WB state, returns to FETCH.
REQ-040 Opcode 0x7F, then ecall -> TRAP, trap = 1 held for 10 cycles; rst pulse -> RST_S, trap = 0, then FETCH.
REQ-041 rst asserted mid-FETCH with mem_req high -> mem_req drops in the same cycle without waiting for a clock edge.
